// File: rtl/spi_master_xfer_ctrl_if.sv
// spi_master_xfer_ctrl_if: request/response handshake and SPI pins of the transfer controller.
interface spi_master_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NO_OF_SLAVES = 1,
  parameter int DIV_WIDTH = 8
);
  localparam int SW = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1;
  logic req_valid, req_ready, req_cpol, req_cpha, req_lsb_first;
  logic [DATA_WIDTH-1:0] req_data, rsp_data;
  logic [SW-1:0] req_slave_sel;
  logic [DIV_WIDTH-1:0] clk_div;
  logic rsp_valid, rsp_err, busy, sclk, mosi0, miso0;
  logic [NO_OF_SLAVES-1:0] cs;
  modport master (
    input req_valid, req_data, req_cpol, req_cpha, req_lsb_first, req_slave_sel, clk_div, miso0,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, sclk, cs, mosi0
  );
  modport slave (
    output req_valid, req_data, req_cpol, req_cpha, req_lsb_first, req_slave_sel, clk_div, miso0,
    input req_ready, rsp_valid, rsp_data, rsp_err, busy, sclk, cs, mosi0
  );
endinterface

// File: rtl/spi_master_xfer_ctrl.sv
// spi_master_xfer_ctrl: one full-duplex SPI frame per request, CPOL/CPHA modes 0-3, MSB/LSB-first.
module spi_master_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NO_OF_SLAVES = 1,
  parameter int DIV_WIDTH = 8
) (
  input logic pclk,
  input logic areset,
  spi_master_xfer_ctrl_if.master bus
);
  localparam int SW = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int TW = $clog2(2 * DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, PREP, SETUP, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic [NO_OF_SLAVES-1:0] cs_q, cs_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [TW-1:0] tog_q, tog_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, init_q;
  logic accept, expiry, sample, last;
  logic [IW-1:0] i_cur, i_drv;
  function automatic logic [IW-1:0] pos(input logic lsb, input logic [IW-1:0] n);
    return lsb ? n : IW'(DATA_WIDTH - 1) - n;
  endfunction
  assign bus.req_ready = state_q == IDLE && init_q && !rsp_valid_q;
  assign accept = bus.req_valid && bus.req_ready;
  assign expiry = cnt_q == '0;
  // tog_q counts completed toggles: even before a leading edge, odd before a trailing edge
  assign sample = tog_q[0] == cpha_q;
  assign last = tog_q == TW'(2 * DATA_WIDTH - 1);
  assign i_cur = IW'(tog_q >> 1);
  assign i_drv = i_cur + IW'(!cpha_q);
  always_comb begin
    state_d = state_q;
    cnt_d = expiry ? div_q : cnt_q - 1'b1;
    div_d = div_q;
    tx_d = tx_q;
    rx_d = rx_q;
    cs_d = cs_q;
    sel_d = sel_q;
    tog_d = tog_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    lsb_d = lsb_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = PREP;
        div_d = bus.clk_div;
        tx_d = bus.req_data;
        rx_d = '0;
        sel_d = bus.req_slave_sel;
        tog_d = '0;
        cpol_d = bus.req_cpol;
        cpha_d = bus.req_cpha;
        lsb_d = bus.req_lsb_first;
        sclk_d = bus.req_cpol;
      end
      PREP: begin
        state_d = SETUP;
        cnt_d = div_q;
        for (int k = 0; k < NO_OF_SLAVES; k++) cs_d[k] = int'(sel_q) != k;
        if (!cpha_q) mosi_d = tx_q[pos(lsb_q, '0)];
      end
      SETUP: if (expiry) state_d = SHIFT;
      SHIFT: if (expiry) begin
        sclk_d = ~sclk_q;
        tog_d = tog_q + 1'b1;
        if (sample) rx_d[pos(lsb_q, i_cur)] = bus.miso0;
        else if (cpha_q || !last) mosi_d = tx_q[pos(lsb_q, i_drv)];
        if (last) state_d = HOLD;
      end
      HOLD: if (expiry) begin
        state_d = IDLE;
        cs_d = '1;
        rsp_valid_d = 1'b1;
        rsp_data_d = rx_q;
        rsp_err_d = int'(sel_q) >= NO_OF_SLAVES;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge areset)
    if (!areset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      cs_q <= '1;
      sel_q <= '0;
      tog_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cs_q <= cs_d;
      sel_q <= sel_d;
      tog_q <= tog_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      lsb_q <= lsb_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      init_q <= 1'b1;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.sclk = sclk_q;
  assign bus.cs = cs_q;
  assign bus.mosi0 = mosi_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// tb_spi_master_xfer_ctrl: directed frames against a bus monitor and an edge-counting SPI slave model.
module tb_spi_master_xfer_ctrl;
  logic clk = 1'b0;
  logic areset = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  spi_master_xfer_ctrl_if #(.DATA_WIDTH(8), .NO_OF_SLAVES(3), .DIV_WIDTH(8)) bus ();
  spi_master_xfer_ctrl #(.DATA_WIDTH(8), .NO_OF_SLAVES(3), .DIV_WIDTH(8)) dut (
    .pclk(clk),
    .areset(areset),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  logic [7:0] sl_word = 8'h00;
  logic loop = 1'b1;
  logic m_cpha = 1'b0, m_lsb = 1'b0, prev_sclk = 1'b0, pre_sclk = 1'b0;
  logic [7:0] mosi_word = 8'h00, s_mosi = 8'h00;
  logic [2:0] cs_seen = 3'b000, s_seen = 3'b000;
  int edges = 0, e1 = 0, e3 = 0, cs_low = 0, busy_cyc = 0, cyc = 0, gap_run = 0, last_gap = 0;
  int rsp_cnt = 0, s_edges = 0, s_period = 0, s_cslow = 0, s_busy = 0;
  logic [2:0] sl_n;
  always_comb sl_n = 3'(m_cpha ? (edges == 0 ? 0 : (edges - 1) / 2) : edges / 2);
  assign bus.miso0 = loop ? bus.mosi0 : sl_word[m_lsb ? sl_n : 3'd7 - sl_n];
  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      m_cpha = bus.req_cpha;
      m_lsb = bus.req_lsb_first;
    end
    if (bus.busy) busy_cyc++;
    if (bus.cs != 3'b111) begin
      if (gap_run != 0) begin
        last_gap = gap_run;
        pre_sclk = prev_sclk;
      end
      gap_run = 0;
      cs_low++;
      cs_seen = cs_seen | ~bus.cs;
      if (bus.sclk != prev_sclk) begin
        edges++;
        if (edges == 1) e1 = cyc;
        if (edges == 3) e3 = cyc;
        if (edges[0] != m_cpha) mosi_word[m_lsb ? (edges - 1) / 2 : 7 - (edges - 1) / 2] = bus.mosi0;
      end
    end else gap_run++;
    if (bus.rsp_valid) begin
      rsp_cnt++;
      s_mosi = mosi_word;
      s_edges = edges;
      s_period = e3 - e1;
      s_cslow = cs_low;
      s_busy = busy_cyc;
      s_seen = cs_seen;
    end else if (!bus.busy) begin
      edges = 0;
      e1 = 0;
      e3 = 0;
      cs_low = 0;
      busy_cyc = 0;
      cs_seen = 3'b000;
      mosi_word = 8'h00;
    end
    prev_sclk = bus.sclk;
    cyc++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input logic [7:0] d, input logic pol, input logic pha, input logic lsb,
                         input logic [1:0] sel, input logic [7:0] div, input logic [7:0] word, input logic lp);
    bus.req_data = d;
    bus.req_cpol = pol;
    bus.req_cpha = pha;
    bus.req_lsb_first = lsb;
    bus.req_slave_sel = sel;
    bus.clk_div = div;
    sl_word = word;
    loop = lp;
    bus.req_valid = 1'b1;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ready_timeout", n < 2000, 1);
  endtask
  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_count", rsp_cnt, target);
  endtask
  task automatic xfer(input logic [7:0] d, input logic pol, input logic pha, input logic lsb,
                      input logic [1:0] sel, input logic [7:0] div, input logic [7:0] word, input logic lp);
    int old;
    @(negedge clk);
    #1;
    old = rsp_cnt;
    set_req(d, pol, pha, lsb, sel, div, word, lp);
    wait_ready();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_rsp(old + 1);
    check("ready_in_rsp_cycle", bus.req_ready, 0);
    @(negedge clk);
    #1;
    check("rsp_one_cycle", bus.rsp_valid, 0);
  endtask
  initial begin
    int old, n;
    bus.req_valid = 1'b0;
    bus.req_data = 8'h00;
    bus.req_cpol = 1'b0;
    bus.req_cpha = 1'b0;
    bus.req_lsb_first = 1'b0;
    bus.req_slave_sel = 2'd0;
    bus.clk_div = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_cs", bus.cs, 3'b111);
    check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi0, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.req_ready, 0);
    areset = 1'b1;
    #1;
    check("ready_first_cycle", bus.req_ready, 0);
    @(negedge clk);
    #1;
    check("ready_second_cycle", bus.req_ready, 1);
    // T1: mode 0 MSB-first, loopback
    xfer(8'hA5, 0, 0, 0, 2'd0, 8'd1, 8'h00, 1);
    check("t1_mosi", s_mosi, 8'hA5);
    check("t1_rsp", bus.rsp_data, 8'hA5);
    check("t1_err", bus.rsp_err, 0);
    check("t1_cs_low", s_cslow, 36);
    check("t1_period", s_period, 4);
    check("t1_edges", s_edges, 16);
    check("t1_busy", s_busy, 37);
    check("t1_cs_seen", s_seen, 3'b001);
    // T2: mode 3 LSB-first, slave returns 0x81
    xfer(8'h3C, 1, 1, 1, 2'd0, 8'd1, 8'h81, 0);
    check("t2_mosi", s_mosi, 8'h3C);
    check("t2_rsp", bus.rsp_data, 8'h81);
    check("t2_sclk_idle", bus.sclk, 1);
    check("t2_edges", s_edges, 16);
    // T3: back-to-back mode 0 then mode 2, clk_div=0
    @(negedge clk);
    #1;
    old = rsp_cnt;
    set_req(8'h96, 0, 0, 0, 2'd0, 8'd0, 8'h00, 1);
    wait_ready();
    @(posedge clk);
    #1;
    set_req(8'h4B, 1, 0, 0, 2'd0, 8'd0, 8'h00, 1);
    wait_ready();
    check("t3a_mosi", s_mosi, 8'h96);
    check("t3a_rsp", bus.rsp_data, 8'h96);
    check("t3a_cs_low", s_cslow, 18);
    check("t3a_pre_sclk", pre_sclk, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_rsp(old + 2);
    check("t3b_rsp", bus.rsp_data, 8'h4B);
    check("t3b_mosi", s_mosi, 8'h4B);
    check("t3b_gap", last_gap >= 1, 1);
    check("t3b_pre_sclk", pre_sclk, 1);
    check("t3b_period", s_period, 2);
    // T4: reset after the 3rd SCLK edge
    xfer(8'h00, 0, 0, 0, 2'd0, 8'd1, 8'h00, 1);
    @(negedge clk);
    #1;
    old = rsp_cnt;
    set_req(8'h66, 0, 0, 0, 2'd0, 8'd1, 8'hC3, 0);
    wait_ready();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (edges < 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_edges_reached", n < 200, 1);
    #2;
    areset = 1'b0;
    #1;
    check("t4_cs_abort", bus.cs, 3'b111);
    check("t4_sclk_abort", bus.sclk, 0);
    check("t4_busy_abort", bus.busy, 0);
    repeat (3) @(negedge clk);
    areset = 1'b1;
    #1;
    check("t4_ready_after_rst", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    check("t4_no_rsp", rsp_cnt, old);
    xfer(8'h5C, 0, 0, 0, 2'd0, 8'd1, 8'h3A, 0);
    check("t4_next_mosi", s_mosi, 8'h5C);
    check("t4_next_rsp", bus.rsp_data, 8'h3A);
    // T5: slave 2, then invalid slave 3
    xfer(8'h5A, 0, 0, 0, 2'd2, 8'd1, 8'h00, 1);
    check("t5_cs_seen", s_seen, 3'b100);
    check("t5_err", bus.rsp_err, 0);
    check("t5_busy", s_busy, 37);
    xfer(8'hE7, 0, 0, 0, 2'd3, 8'd1, 8'h00, 1);
    check("t5_bad_cs_seen", s_seen, 3'b000);
    check("t5_bad_err", bus.rsp_err, 1);
    check("t5_bad_rsp", bus.rsp_data, 8'hE7);
    check("t5_bad_busy", s_busy, 37);
    // T6: modes 1 and 2, clk_div=3
    xfer(8'hC3, 0, 1, 0, 2'd1, 8'd3, 8'h96, 0);
    check("t6m1_mosi", s_mosi, 8'hC3);
    check("t6m1_rsp", bus.rsp_data, 8'h96);
    check("t6m1_period", s_period, 8);
    check("t6m1_cs_low", s_cslow, 72);
    check("t6m1_cs_seen", s_seen, 3'b010);
    xfer(8'h29, 1, 0, 0, 2'd0, 8'd3, 8'h5E, 0);
    check("t6m2_mosi", s_mosi, 8'h29);
    check("t6m2_rsp", bus.rsp_data, 8'h5E);
    check("t6m2_period", s_period, 8);
    check("t6m2_cs_low", s_cslow, 72);
    check("t6m2_sclk_idle", bus.sclk, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
